// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: load-use bubbles, multi-cycle
// data-memory freeze with timeout, taken-branch flush and a stall performance counter.
module pipe_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       rs1_from_id,
    input  logic [4:0]       rs2_from_id,
    input  logic             rs1_used_from_id,
    input  logic             rs2_used_from_id,
    input  logic [4:0]       rd_from_ex,
    input  logic             read_mem_from_ex,
    input  logic             branch_taken_from_ex,
    input  logic             mem_req_from_mem,
    input  logic             mem_ready,
    output logic             pc_stall,
    output logic             if_id_stall,
    output logic             id_stall_req,
    output logic             if_id_flush,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt
);
    localparam int WW = $clog2(MEM_TIMEOUT) + 1;
    localparam logic [WW-1:0] WAIT_LAST = WW'(MEM_TIMEOUT - 1);

    typedef enum logic [1:0] {RUN, MEM_WAIT, ERR} state_t;

    state_t        state, state_nx;
    logic [WW-1:0] wait_cnt, wait_cnt_nx;
    logic          mem_err_q, mem_err_nx;
    logic          load_use, mem_block;
    logic          run_stall, run_bubble, run_flush;

    assign load_use = read_mem_from_ex && (rd_from_ex != 5'd0) &&
                      ((rs1_used_from_id && (rs1_from_id == rd_from_ex)) ||
                       (rs2_used_from_id && (rs2_from_id == rd_from_ex)));
    assign mem_block = mem_req_from_mem && !mem_ready;

    // A taken branch kills the ID instruction, so its load-use hazard is moot.
    assign run_flush  = branch_taken_from_ex;
    assign run_bubble = branch_taken_from_ex || load_use;
    assign run_stall  = !branch_taken_from_ex && load_use;

    always_comb begin
        state_nx     = state;
        wait_cnt_nx  = wait_cnt;
        mem_err_nx   = mem_err_q;
        pc_stall     = 1'b0;
        if_id_stall  = 1'b0;
        id_stall_req = 1'b0;
        if_id_flush  = 1'b0;
        case (state)
            RUN: begin
                if (mem_block) begin
                    pc_stall    = 1'b1;
                    if_id_stall = 1'b1;
                    state_nx    = MEM_WAIT;
                    wait_cnt_nx = WW'(1);
                end else begin
                    pc_stall     = run_stall;
                    if_id_stall  = run_stall;
                    id_stall_req = run_bubble;
                    if_id_flush  = run_flush;
                end
            end
            MEM_WAIT: begin
                if (mem_ready) begin
                    pc_stall     = run_stall;
                    if_id_stall  = run_stall;
                    id_stall_req = run_bubble;
                    if_id_flush  = run_flush;
                    state_nx     = RUN;
                    wait_cnt_nx  = '0;
                end else begin
                    pc_stall    = 1'b1;
                    if_id_stall = 1'b1;
                    if (wait_cnt == WAIT_LAST) begin
                        state_nx   = ERR;
                        mem_err_nx = 1'b1;
                    end else begin
                        wait_cnt_nx = wait_cnt + WW'(1);
                    end
                end
            end
            ERR: begin
                pc_stall    = 1'b1;
                if_id_stall = 1'b1;
            end
            default: state_nx = RUN;
        endcase
        if (rst) begin
            pc_stall     = 1'b0;
            if_id_stall  = 1'b0;
            id_stall_req = 1'b0;
            if_id_flush  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RUN;
            wait_cnt  <= '0;
            mem_err_q <= 1'b0;
            stall_cnt <= '0;
        end else begin
            state     <= state_nx;
            wait_cnt  <= wait_cnt_nx;
            mem_err_q <= mem_err_nx;
            if (pc_stall && (stall_cnt != {CNT_W{1'b1}}))
                stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

    assign mem_err = mem_err_q && !rst;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Randomized bench for pipe_hazard_ctrl against a cycle-level behavioural model,
// plus directed load-use, branch, memory-wait, timeout and saturation scenarios.
module tb_pipe_hazard_ctrl;
    localparam int T    = 4;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic [4:0]    rs1, rs2, rd;
    logic          u1, u2, rm, br, mq, mr;
    logic          pc_stall, if_id_stall, id_stall_req, if_id_flush, mem_err;
    logic [CW-1:0] stall_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    // model state: sticky error, consecutive blocked-cycle age, stall count
    bit m_err;
    int m_age;
    int m_cnt;

    pipe_hazard_ctrl #(.MEM_TIMEOUT(T), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .rs1_from_id(rs1), .rs2_from_id(rs2),
        .rs1_used_from_id(u1), .rs2_used_from_id(u2),
        .rd_from_ex(rd), .read_mem_from_ex(rm),
        .branch_taken_from_ex(br), .mem_req_from_mem(mq), .mem_ready(mr),
        .pc_stall(pc_stall), .if_id_stall(if_id_stall), .id_stall_req(id_stall_req),
        .if_id_flush(if_id_flush), .mem_err(mem_err), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Apply one cycle of inputs, check outputs against the model, then clock it.
    task automatic step(input bit r, input bit [4:0] a1, input bit [4:0] a2, input bit e1,
                        input bit e2, input bit [4:0] d, input bit ld, input bit b,
                        input bit q, input bit y);
        bit lu, ps, ist, bub, fl, nerr;
        int nage;
        @(negedge clk);
        rst = r; rs1 = a1; rs2 = a2; u1 = e1; u2 = e2; rd = d; rm = ld; br = b; mq = q; mr = y;
        #1;
        lu = ld && (d != 0) && ((e1 && a1 == d) || (e2 && a2 == d));
        {ps, ist, bub, fl} = 4'b0;
        nerr = m_err;
        nage = m_age;
        if (r) begin
            // everything quiet during reset
        end else if (m_err) begin
            ps = 1; ist = 1;
        end else if (m_age > 0 && !y) begin
            ps = 1; ist = 1;
            nage = m_age + 1;
            if (nage == T) nerr = 1;
        end else if (m_age == 0 && q && !y) begin
            ps = 1; ist = 1;
            nage = 1;
        end else begin
            nage = 0;
            if (b) begin
                fl = 1; bub = 1;
            end else if (lu) begin
                ps = 1; ist = 1; bub = 1;
            end
        end
        chk("pc_stall", 32'(pc_stall), 32'(ps));
        chk("if_id_stall", 32'(if_id_stall), 32'(ist));
        chk("id_stall_req", 32'(id_stall_req), 32'(bub));
        chk("if_id_flush", 32'(if_id_flush), 32'(fl));
        chk("mem_err", 32'(mem_err), 32'(m_err && !r));
        chk("stall_cnt", 32'(stall_cnt), 32'(m_cnt));
        @(posedge clk);
        if (r) begin
            m_err = 0; m_age = 0; m_cnt = 0;
        end else begin
            m_err = nerr; m_age = nage;
            if (ps && m_cnt < CMAX) m_cnt++;
        end
    endtask

    task automatic idle(input bit r);
        step(r, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        rst = 1; {rs1, rs2, rd} = '0; {u1, u2, rm, br, mq, mr} = '0;
        @(posedge clk);
        m_err = 0; m_age = 0; m_cnt = 0;
        idle(1);
        idle(0);

        // load-use: lw x5 in EX, add reading x5 in ID -> one bubble
        step(0, 5, 1, 1, 1, 5, 1, 0, 0, 0);
        idle(0);
        chk("lu_cnt", 32'(stall_cnt), 32'd1);
        // rd=0, and an unused rs2 match: no stall
        step(0, 0, 0, 1, 1, 0, 1, 0, 0, 0);
        step(0, 1, 7, 1, 0, 7, 1, 0, 0, 0);
        // branch beats load-use
        step(0, 5, 1, 1, 0, 5, 1, 1, 0, 0);

        // memory wait: three blocked cycles, ready on the fourth
        idle(1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        step(0, 3, 0, 1, 0, 3, 1, 0, 1, 1);
        idle(0);
        chk("wait_cnt3", 32'(stall_cnt), 32'd4);

        // timeout then reset
        idle(1);
        for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
        chk("timeout_err", 32'(mem_err), 32'd1);
        idle(1);
        idle(0);
        chk("rst_cnt", 32'(stall_cnt), 32'd0);

        // saturation: stuck in error for 20 cycles
        for (int i = 0; i < 20; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        idle(0);
        chk("sat_cnt", 32'(stall_cnt), 32'(CMAX));
        idle(1);

        // randomized traffic, alternating fast and slow memory phases
        for (int i = 0; i < 3000; i++) begin
            bit slow;
            slow = ((i / 200) % 2) == 1;
            step($urandom_range(0, 59) == 0,
                 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                 1'($urandom), 1'($urandom), 5'($urandom_range(0, 3)),
                 1'($urandom), $urandom_range(0, 3) == 0,
                 $urandom_range(0, 9) < 3,
                 slow ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 1) == 1));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
